// File: rtl/i2c_slave_port.sv
// I2C slave target: oversamples SCL/SDA, matches a fixed 7-bit address and moves
// bytes between the bus and a byte-wide local interface. SCL is never stretched.
module i2c_slave_port #(
    parameter logic [6:0] SLAVE_ADDR = 7'h3A
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       scl,
    inout  wire        sda,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK, IGNORE
    } state_t;

    state_t     state, state_next;
    logic [1:0] scl_sync, sda_sync;
    logic       scl_prev, sda_prev;
    logic [2:0] bit_cnt, bit_cnt_next;
    logic [7:0] shifter, shifter_next;
    logic       byte_done, byte_done_next;
    logic       master_ack, master_ack_next;
    logic       sda_low, sda_low_next;
    logic       busy_next;
    logic [7:0] rx_data_next;
    logic       rx_valid_next;
    logic       tx_load;
    logic       scl_rise, scl_fall, start_det, stop_det, sda_in;

    // Synchronizers reset to the idle-bus level so reset never fakes a START.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], scl};
            sda_sync <= {sda_sync[0], sda};
            scl_prev <= scl_sync[1];
            sda_prev <= sda_sync[1];
        end
    end

    assign sda_in    = sda_sync[1];
    assign scl_rise  = scl_sync[1] & ~scl_prev;
    assign scl_fall  = ~scl_sync[1] & scl_prev;
    assign start_det = scl_sync[1] & scl_prev & sda_prev & ~sda_in;
    assign stop_det  = scl_sync[1] & scl_prev & ~sda_prev & sda_in;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state      <= IDLE;
            bit_cnt    <= 3'd0;
            shifter    <= 8'h00;
            byte_done  <= 1'b0;
            master_ack <= 1'b0;
            sda_low    <= 1'b0;
            busy       <= 1'b0;
            rx_data    <= 8'h00;
            rx_valid   <= 1'b0;
        end else begin
            state      <= state_next;
            bit_cnt    <= bit_cnt_next;
            shifter    <= shifter_next;
            byte_done  <= byte_done_next;
            master_ack <= master_ack_next;
            sda_low    <= sda_low_next;
            busy       <= busy_next;
            rx_data    <= rx_data_next;
            rx_valid   <= rx_valid_next;
        end
    end

    // Bus conditions take priority over any SCL edge seen in the same cycle.
    always_comb begin
        state_next      = state;
        bit_cnt_next    = bit_cnt;
        shifter_next    = shifter;
        byte_done_next  = byte_done;
        master_ack_next = master_ack;
        sda_low_next    = sda_low;
        busy_next       = busy;
        rx_data_next    = rx_data;
        rx_valid_next   = 1'b0;
        tx_load         = 1'b0;

        if (stop_det) begin
            state_next     = IDLE;
            bit_cnt_next   = 3'd0;
            byte_done_next = 1'b0;
            sda_low_next   = 1'b0;
            busy_next      = 1'b0;
        end else if (start_det) begin
            state_next     = ADDR;
            bit_cnt_next   = 3'd0;
            byte_done_next = 1'b0;
            sda_low_next   = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                end
                ADDR: begin
                    if (scl_rise) begin
                        shifter_next   = {shifter[6:0], sda_in};
                        bit_cnt_next   = bit_cnt + 3'd1;
                        byte_done_next = (bit_cnt == 3'd7);
                    end else if (scl_fall && byte_done) begin
                        byte_done_next = 1'b0;
                        if (shifter[7:1] == SLAVE_ADDR) begin
                            sda_low_next = 1'b1;
                            busy_next    = 1'b1;
                            state_next   = ADDR_ACK;
                        end else begin
                            sda_low_next = 1'b0;
                            busy_next    = 1'b0;
                            state_next   = IGNORE;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        sda_low_next = 1'b0;
                        bit_cnt_next = 3'd0;
                        if (shifter[0]) begin
                            tx_load      = 1'b1;
                            shifter_next = tx_data;
                            sda_low_next = ~tx_data[7];
                            state_next   = READ;
                        end else begin
                            state_next = WRITE;
                        end
                    end
                end
                WRITE: begin
                    if (scl_rise) begin
                        shifter_next = {shifter[6:0], sda_in};
                        bit_cnt_next = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            rx_data_next   = {shifter[6:0], sda_in};
                            rx_valid_next  = 1'b1;
                            byte_done_next = 1'b1;
                        end
                    end else if (scl_fall && byte_done) begin
                        byte_done_next = 1'b0;
                        sda_low_next   = 1'b1;
                        state_next     = WRITE_ACK;
                    end
                end
                WRITE_ACK: begin
                    if (scl_fall) begin
                        sda_low_next = 1'b0;
                        bit_cnt_next = 3'd0;
                        state_next   = WRITE;
                    end
                end
                READ: begin
                    if (scl_fall) begin
                        if (bit_cnt == 3'd7) begin
                            sda_low_next    = 1'b0;
                            bit_cnt_next    = 3'd0;
                            master_ack_next = 1'b0;
                            state_next      = READ_ACK;
                        end else begin
                            shifter_next = {shifter[6:0], 1'b0};
                            sda_low_next = ~shifter[6];
                            bit_cnt_next = bit_cnt + 3'd1;
                        end
                    end
                end
                READ_ACK: begin
                    if (scl_rise) begin
                        master_ack_next = ~sda_in;
                    end else if (scl_fall) begin
                        bit_cnt_next = 3'd0;
                        if (master_ack) begin
                            tx_load      = 1'b1;
                            shifter_next = tx_data;
                            sda_low_next = ~tx_data[7];
                            state_next   = READ;
                        end else begin
                            sda_low_next = 1'b0;
                            state_next   = IGNORE;
                        end
                    end
                end
                IGNORE: begin
                    sda_low_next = 1'b0;
                end
                default: begin
                    state_next   = IDLE;
                    sda_low_next = 1'b0;
                end
            endcase
        end
    end

    assign tx_req = tx_load & reset_n;
    assign sda    = sda_low ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_slave_port.sv
// Bus-level bench: acts as I2C master and checks the slave against transaction-level
// expectations (address match, ACK slots, received/returned bytes, busy).
module tb_i2c_slave_port;

    localparam int Q = 10;
    localparam logic [6:0] MY_ADDR = 7'h3A;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       scl;
    logic       m_sda_low;
    logic [7:0] tx_data;
    wire        sda;
    wire  [7:0] rx_data;
    wire        rx_valid, tx_req, busy;

    int checks = 0;
    int passes = 0;

    logic [7:0] rx_log[$];
    int         tx_req_count = 0;
    logic [7:0] payload[4];

    always #5 clock = ~clock;

    assign sda = m_sda_low ? 1'b0 : 1'bz;
    pullup (sda);

    i2c_slave_port #(.SLAVE_ADDR(MY_ADDR)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .scl      (scl),
        .sda      (sda),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_req   (tx_req),
        .busy     (busy)
    );

    // Record every byte delivered and every shifter load.
    always @(negedge clock) begin
        if (rx_valid) rx_log.push_back(rx_data);
        if (tx_req) tx_req_count++;
    end

    initial begin
        #5ms;
        $display("[TB] FAIL watchdog: simulation still running, required finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    endtask

    task automatic waitClk(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic applyBit(input logic b, output logic r);
        m_sda_low = ~b;
        waitClk(Q);
        scl = 1'b1;
        waitClk(Q / 2);
        r = sda;
        waitClk(Q - Q / 2);
        scl = 1'b0;
        waitClk(Q);
    endtask

    task automatic applyStart();
        m_sda_low = 1'b0;
        waitClk(Q);
        scl = 1'b1;
        waitClk(Q);
        m_sda_low = 1'b1;
        waitClk(Q);
        scl = 1'b0;
        waitClk(Q);
    endtask

    task automatic applyStop();
        m_sda_low = 1'b1;
        waitClk(Q);
        scl = 1'b1;
        waitClk(Q);
        m_sda_low = 1'b0;
        waitClk(Q);
    endtask

    task automatic writeByte(input logic [7:0] b, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) applyBit(b[i], r);
        applyBit(1'b1, ack);
    endtask

    task automatic readByte(input logic nack, output logic [7:0] v);
        logic r;
        v = 8'h00;
        for (int i = 0; i < 8; i++) begin
            applyBit(1'b1, r);
            v = {v[6:0], r};
        end
        applyBit(nack, r);
    endtask

    // One complete transaction; a matching address means every slot is ACKed,
    // writes arrive in order on rx_data and reads return payload in order.
    task automatic applyStimulus(input logic [6:0] addr, input logic rw, input int nbytes);
        logic       ack;
        logic [7:0] v;
        logic       match;
        int         rx0, tx0, exp_rx, exp_tx;
        match = (addr == MY_ADDR);
        rx0 = rx_log.size();
        tx0 = tx_req_count;
        if (rw) tx_data = payload[0];
        applyStart();
        writeByte({addr, rw}, ack);
        checkOutput("addr_ack", ack, match ? 0 : 1);
        checkOutput("busy_after_addr", busy, match);
        for (int i = 0; i < nbytes; i++) begin
            if (!rw) begin
                writeByte(payload[i], ack);
                checkOutput("write_ack", ack, match ? 0 : 1);
            end else begin
                if (i + 1 < nbytes) tx_data = payload[i + 1];
                readByte(i == nbytes - 1, v);
                checkOutput("read_byte", v, match ? payload[i] : 8'hFF);
            end
        end
        applyStop();
        waitClk(4);
        checkOutput("busy_after_stop", busy, 0);
        checkOutput("sda_released", sda, 1);
        exp_rx = (match && !rw) ? nbytes : 0;
        exp_tx = (match && rw) ? nbytes : 0;
        checkOutput("rx_valid_count", rx_log.size() - rx0, exp_rx);
        checkOutput("tx_req_count", tx_req_count - tx0, exp_tx);
        for (int i = 0; i < exp_rx; i++)
            if (rx0 + i < rx_log.size()) checkOutput("rx_data", rx_log[rx0 + i], payload[i]);
    endtask

    initial begin
        logic       ack, r;
        logic [7:0] v, t;
        logic [6:0] a;
        int         rx0, tx0;

        reset_n   = 1'b0;
        scl       = 1'b1;
        m_sda_low = 1'b0;
        tx_data   = 8'h00;
        waitClk(4);
        reset_n = 1'b1;
        waitClk(2);
        checkOutput("reset_rx_data", rx_data, 8'h00);
        checkOutput("reset_rx_valid", rx_valid, 0);
        checkOutput("reset_tx_req", tx_req, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_sda", sda, 1);

        payload[0] = 8'hA5;
        applyStimulus(7'h3A, 1'b0, 1);

        payload[0] = 8'hFF;
        applyStimulus(7'h3B, 1'b0, 1);

        payload[0] = 8'h5C;
        payload[1] = 8'hC3;
        applyStimulus(7'h3A, 1'b1, 2);

        // Write then repeated START into a read, no STOP in between.
        rx0 = rx_log.size();
        tx0 = tx_req_count;
        applyStart();
        writeByte(8'h74, ack);
        checkOutput("rs_addr_ack", ack, 0);
        writeByte(8'h12, ack);
        checkOutput("rs_write_ack", ack, 0);
        checkOutput("rs_rx_count", rx_log.size() - rx0, 1);
        if (rx_log.size() > rx0) checkOutput("rs_rx_data", rx_log[rx0], 8'h12);
        t = 8'($urandom);
        tx_data = t;
        applyStart();
        checkOutput("rs_busy_after_start", busy, 1);
        writeByte(8'h75, ack);
        checkOutput("rs_read_addr_ack", ack, 0);
        checkOutput("rs_busy_read", busy, 1);
        readByte(1'b1, v);
        checkOutput("rs_read_byte", v, t);
        checkOutput("rs_busy_end", busy, 1);
        applyStop();
        waitClk(4);
        checkOutput("rs_tx_req_count", tx_req_count - tx0, 1);
        checkOutput("rs_busy_stop", busy, 0);

        // STOP after four data bits discards the partial byte.
        rx0 = rx_log.size();
        applyStart();
        writeByte(8'h74, ack);
        checkOutput("abort_addr_ack", ack, 0);
        for (int i = 0; i < 4; i++) applyBit(i[0], r);
        applyStop();
        waitClk(4);
        checkOutput("abort_rx_count", rx_log.size() - rx0, 0);
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_sda", sda, 1);

        // Reset while the slave drives a 0 data bit.
        tx_data = 8'h00;
        applyStart();
        writeByte(8'h75, ack);
        checkOutput("rst_addr_ack", ack, 0);
        checkOutput("rst_driving_zero", sda, 0);
        reset_n = 1'b0;
        waitClk(1);
        reset_n = 1'b1;
        checkOutput("rst_sda_released", sda, 1);
        checkOutput("rst_rx_data", rx_data, 8'h00);
        checkOutput("rst_rx_valid", rx_valid, 0);
        checkOutput("rst_tx_req", tx_req, 0);
        checkOutput("rst_busy", busy, 0);
        applyStop();
        waitClk(4);

        for (int n = 0; n < 16; n++) begin
            if ($urandom_range(0, 1) == 1) a = MY_ADDR;
            else begin
                a = 7'($urandom);
                while (a == MY_ADDR) a = 7'($urandom);
            end
            for (int i = 0; i < 4; i++) payload[i] = 8'($urandom);
            applyStimulus(a, 1'($urandom_range(0, 1)), int'($urandom_range(1, 3)));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
